// File: rtl/mix_engine.sv
// Lane-mixing engine: LANES words of WIDTH bits, one lane update per clock through a fixed
// INC/CHAIN then ROUNDS x (ADD/XOR/SHIFT) schedule, with valid/ready handshakes on both sides.
module mix_engine #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ROUNDS = 10,
    parameter int unsigned SHL    = 16,
    parameter int unsigned SHR_A  = 17,
    parameter int unsigned SHR_B  = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_chain,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   busy
);

    localparam int unsigned KW = $clog2(LANES);
    localparam int unsigned RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [KW-1:0] KLast = KW'(LANES - 1);
    localparam logic [KW-1:0] Half  = KW'(LANES / 2);
    localparam logic [RW-1:0] RLast = (ROUNDS > 0) ? RW'(ROUNDS - 1) : '0;

    typedef enum logic [2:0] {StIdle, StInc, StChain, StAdd, StXor, StShift, StDone} state_t;

    state_t            state_q;
    logic [KW-1:0]     k_q;
    logic [RW-1:0]     r_q;
    logic              idle_q;
    logic              out_valid_q;
    logic              busy_q;
    logic [WIDTH-1:0]  lanes_q [LANES];

    logic [KW-1:0]     k_m1, k_p1, k_p2, k_h, k_hp1, k_hm1;
    logic [WIDTH-1:0]  lane_cur, lane_new;

    // Lane indices wrap for free because LANES is a power of two.
    assign k_m1  = k_q - KW'(1);
    assign k_p1  = k_q + KW'(1);
    assign k_p2  = k_q + KW'(2);
    assign k_h   = k_q + Half;
    assign k_hp1 = k_h + KW'(1);
    assign k_hm1 = k_h - KW'(1);
    assign lane_cur = lanes_q[k_q];

    always_comb begin
        lane_new = lane_cur;
        unique case (state_q)
            StInc:   lane_new = lane_cur + WIDTH'(k_q);
            StChain: lane_new = lane_cur + lanes_q[k_m1];
            StAdd:   lane_new = lane_cur + lanes_q[k_p1] - lanes_q[k_hp1];
            StXor:   lane_new = lane_cur ^ (lanes_q[k_hm1] << SHL);
            StShift: lane_new = lane_cur - (lanes_q[k_p2] >> SHR_A) + (lanes_q[k_h] >> SHR_B);
            default: lane_new = lane_cur;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_q         <= '0;
            r_q         <= '0;
            idle_q      <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < LANES; i++) lanes_q[i] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (!in_chain) begin
                            for (int i = 0; i < LANES; i++) lanes_q[i] <= in_data[i*WIDTH +: WIDTH];
                        end
                        state_q <= StInc;
                        k_q     <= '0;
                        r_q     <= '0;
                        idle_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        idle_q      <= 1'b1;
                    end
                end
                default: begin
                    lanes_q[k_q] <= lane_new;
                    k_q          <= k_q + KW'(1);
                    if (k_q == KLast) begin
                        case (state_q)
                            StInc:   state_q <= StChain;
                            StChain: begin
                                if (ROUNDS == 0) begin
                                    state_q     <= StDone;
                                    busy_q      <= 1'b0;
                                    out_valid_q <= 1'b1;
                                end else begin
                                    state_q <= StAdd;
                                end
                            end
                            StAdd:   state_q <= StXor;
                            StXor:   state_q <= StShift;
                            StShift: begin
                                if (r_q == RLast) begin
                                    state_q     <= StDone;
                                    busy_q      <= 1'b0;
                                    out_valid_q <= 1'b1;
                                end else begin
                                    state_q <= StAdd;
                                    r_q     <= r_q + RW'(1);
                                end
                            end
                            default: state_q <= StIdle;
                        endcase
                    end
                end
            endcase
        end
    end

    // in_ready must drop combinationally while reset is asserted.
    assign in_ready  = idle_q & rst_n;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    for (genvar g = 0; g < LANES; g++) begin : g_out
        assign out_data[g*WIDTH +: WIDTH] = lanes_q[g];
    end

endmodule

// File: tb/tb_mix_engine.sv
// Bench for mix_engine: three configurations checked against a direct rule-by-rule model.
module tb_mix_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   vld, chn, rdy, ir, ov, bz;
    logic [511:0] din;
    logic [31:0]  od_a;
    logic [255:0] od_b;
    logic [511:0] od_c;

    int total = 0;
    int bad   = 0;

    int cfg_l [3] = '{4, 8, 16};
    int cfg_w [3] = '{8, 32, 32};
    int cfg_r [3] = '{0, 10, 3};
    int cfg_s [3] = '{4, 16, 16};
    int cfg_a [3] = '{5, 17, 17};
    int cfg_b [3] = '{3, 12, 12};

    logic [63:0] ms [3][16];

    always #5 clk = ~clk;

    mix_engine #(.LANES(4), .WIDTH(8), .ROUNDS(0), .SHL(4), .SHR_A(5), .SHR_B(3)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(ir[0]), .in_chain(chn[0]),
        .in_data(din[31:0]), .out_valid(ov[0]), .out_ready(rdy[0]), .out_data(od_a), .busy(bz[0])
    );

    mix_engine u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(ir[1]), .in_chain(chn[1]),
        .in_data(din[255:0]), .out_valid(ov[1]), .out_ready(rdy[1]), .out_data(od_b), .busy(bz[1])
    );

    mix_engine #(.LANES(16), .ROUNDS(3)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(ir[2]), .in_chain(chn[2]),
        .in_data(din), .out_valid(ov[2]), .out_ready(rdy[2]), .out_data(od_c), .busy(bz[2])
    );

    function automatic logic [511:0] get_od(input int sel);
        case (sel)
            0:       return 512'(od_a);
            1:       return 512'(od_b);
            default: return od_c;
        endcase
    endfunction

    function automatic logic [511:0] pack_model(input int sel);
        logic [511:0] p = '0;
        for (int i = 0; i < cfg_l[sel]; i++) p |= 512'(ms[sel][i]) << (i * cfg_w[sel]);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the schedule literally: each phase walks the lanes in order, updating in place.
    task automatic model_run(input int sel);
        int L = cfg_l[sel];
        logic [63:0] m = (64'd1 << cfg_w[sel]) - 64'd1;
        for (int k = 0; k < L; k++) ms[sel][k] = (ms[sel][k] + 64'(k)) & m;
        for (int k = 0; k < L; k++) ms[sel][k] = (ms[sel][k] + ms[sel][(k + L - 1) % L]) & m;
        for (int r = 0; r < cfg_r[sel]; r++) begin
            for (int k = 0; k < L; k++)
                ms[sel][k] = (ms[sel][k] + ms[sel][(k + 1) % L] - ms[sel][(k + L/2 + 1) % L]) & m;
            for (int k = 0; k < L; k++)
                ms[sel][k] = (ms[sel][k] ^ (ms[sel][(k + L/2 - 1) % L] << cfg_s[sel])) & m;
            for (int k = 0; k < L; k++)
                ms[sel][k] = (ms[sel][k] - (ms[sel][(k + 2) % L] >> cfg_a[sel])
                              + (ms[sel][(k + L/2) % L] >> cfg_b[sel])) & m;
        end
    endtask

    task automatic run_batch(input int sel, input bit chain, input int hold, input int exp_lat,
                             input string tag);
        logic [63:0]  m = (64'd1 << cfg_w[sel]) - 64'd1;
        logic [511:0] snap;
        int lat = 0;
        bit irbad = 0;
        bit stable = 1;
        @(negedge clk);
        chn[sel] = chain;
        vld[sel] = 1'b1;
        chk({tag, "_ready_pre"}, 512'(ir[sel]), 512'(1));
        @(posedge clk);
        #1;
        vld[sel] = 1'b0;
        if (!chain)
            for (int i = 0; i < cfg_l[sel]; i++) ms[sel][i] = 64'(din >> (i * cfg_w[sel])) & m;
        model_run(sel);
        chk({tag, "_busy"}, 512'(bz[sel]), 512'(1));
        while (!ov[sel] && lat < 3000) begin
            if (lat == 20) begin
                vld[sel] = 1'b1;
                chn[sel] = ~chain;
            end
            if (lat == 24) vld[sel] = 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (ir[sel]) irbad = 1;
        end
        vld[sel] = 1'b0;
        chk({tag, "_latency"}, 512'(lat), 512'(exp_lat));
        chk({tag, "_ready_busy"}, 512'(irbad), 512'(0));
        chk({tag, "_data"}, get_od(sel), pack_model(sel));
        snap = get_od(sel);
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (get_od(sel) !== snap || !ov[sel] || ir[sel] || bz[sel]) stable = 0;
        end
        chk({tag, "_hold"}, 512'(stable), 512'(1));
        @(negedge clk);
        rdy[sel] = 1'b1;
        @(posedge clk);
        #1;
        rdy[sel] = 1'b0;
        chk({tag, "_valid_drop"}, 512'(ov[sel]), 512'(0));
        chk({tag, "_ready_back"}, 512'(ir[sel]), 512'(1));
    endtask

    initial begin
        bit rose;
        rst_n = 1'b0;
        vld = '0;
        chn = '0;
        rdy = '0;
        din = '0;
        for (int s = 0; s < 3; s++) for (int i = 0; i < 16; i++) ms[s][i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_low", 512'(ir), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_high", 512'(ir), 512'(3'b111));
        chk("rst_valid", 512'(ov), 512'(0));
        chk("rst_busy", 512'(bz), 512'(0));
        chk("rst_data", od_c | 512'(od_b) | 512'(od_a), 512'(0));

        // Small configuration: known golden values including wrap-around.
        din = '0;
        run_batch(0, 1'b0, 0, 8, "a_zero");
        chk("a_zero_gold", 512'(od_a), 512'(32'h09060403));
        run_batch(0, 1'b1, 2, 8, "a_chain");
        chk("a_chain_gold", 512'(od_a), 512'(32'h281C140F));
        din[31:0] = 32'hFFFF_FFFF;
        run_batch(0, 1'b0, 0, 8, "a_wrap");
        chk("a_wrap_gold", 512'(od_a), 512'(32'h04020101));

        // Default configuration with back-pressure.
        din = '0;
        for (int i = 0; i < 8; i++) din[i*32 +: 32] = i;
        run_batch(1, 1'b0, 20, 256, "b_ramp");

        // Reset mid-batch discards the batch.
        for (int i = 0; i < 8; i++) din[i*32 +: 32] = $urandom();
        @(negedge clk);
        chn[1] = 1'b0;
        vld[1] = 1'b1;
        @(posedge clk);
        #1;
        vld[1] = 1'b0;
        repeat (99) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_ready_low", 512'(ir[1]), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) for (int i = 0; i < 16; i++) ms[s][i] = '0;
        chk("mid_rst_ready", 512'(ir[1]), 512'(1));
        chk("mid_rst_data", 512'(od_b), 512'(0));
        rose = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (ov[1] || bz[1]) rose = 1;
        end
        chk("mid_rst_no_valid", 512'(rose), 512'(0));
        for (int i = 0; i < 8; i++) din[i*32 +: 32] = $urandom();
        run_batch(1, 1'b0, 3, 256, "b_after_rst");

        // Random fresh and chained batches on the 16-lane configuration.
        for (int n = 0; n < 50; n++) begin
            bit c = 1'($urandom_range(0, 1));
            if (!c) for (int i = 0; i < 16; i++) din[i*32 +: 32] = $urandom();
            run_batch(2, c, $urandom_range(0, 5), 176, "c_rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mix_engine.md
# mix_engine

Parametrised, synthesizable lane-mixing engine: holds LANES words of WIDTH bits and applies a fixed add/xor/shift mixing schedule over a configurable number of rounds, one lane update per clock. Used as the workload core for simulator and back-end benchmarking, replacing hand-unrolled behavioural mixers with a single handshaked block that runs fresh or chained batches.

## Interface
- LANES, 8, lane count; power of two, >= 4
- WIDTH, 32, lane word width
- ROUNDS, 10, mixing rounds per batch; 0 legal
- SHL, 16, left-shift amount in XOR phase; < WIDTH
- SHR_A, 17, first right-shift amount in SHIFT phase; < WIDTH
- SHR_B, 12, second right-shift amount in SHIFT phase; < WIDTH

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  batch request
- in_ready  out  1  engine idle, can accept
- in_chain  in  1  1: mix current internal state; 0: load in_data
- in_data  in  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]
- out_valid  out  1  result held on out_data
- out_ready  in  1  consumer takes result
- out_data  out  LANES*WIDTH  lane registers, same packing
- busy  out  1  computing (not IDLE, not DONE)

## Operation
- States: IDLE, INC, CHAIN, ADD, XOR, SHIFT, DONE. Lane counter k (0..LANES-1), round counter r (0..ROUNDS-1).
- All arithmetic modulo 2^WIDTH; shifts logical, zero fill. Indices mod LANES. o[] = lane registers; each step reads current register values (lanes already updated this phase are seen updated).
- IDLE: in_ready=1. On in_valid: if in_chain=0, o[] <= in_data; if 1, o[] unchanged. -> INC, k=0, r=0.
- INC, lane k: o[k] += k.
- CHAIN, lane k: o[k] += o[k-1].
- ADD, lane k: o[k] = o[k] + o[k+1] - o[k+LANES/2+1].
- XOR, lane k: o[k] = o[k] ^ (o[k+LANES/2-1] << SHL).
- SHIFT, lane k: o[k] = o[k] - (o[k+2] >> SHR_A) + (o[k+LANES/2] >> SHR_B).
- Each state runs k=0..LANES-1, then advances: INC->CHAIN->ADD->XOR->SHIFT; SHIFT with r<ROUNDS-1 -> ADD, r+1; SHIFT last round -> DONE. ROUNDS=0: CHAIN -> DONE.
- DONE: out_valid=1, out_data stable. On out_ready -> IDLE. o[] retained for later chain batches.
- out_data always equals o[]; valid only when out_valid=1.
- Reset (rst_n=0 at an edge, any state incl. mid-batch): state IDLE, k=0, r=0, o[] all 0, out_valid 0; batch discarded, no out_valid. in_ready forced 0 while rst_n low.

## Timing
- Reset values: in_ready 0 during reset then 1, out_valid 0, busy 0, out_data 0.
- N = LANES*(2 + 3*ROUNDS) compute cycles. Accept edge T (in_valid&&in_ready); busy=1 from T+1; last lane update at edge T+N; out_valid=1 and busy=0 from T+N.
- out_ready sampled only in DONE; accept edge D -> out_valid 0, in_ready 1 from D+1. Earliest next accept at D+1. Consumer back-pressure holds DONE indefinitely.
- in_valid/in_chain/in_data ignored outside IDLE. in_ready and out_valid never both 1.
- Defaults: N = 8*32 = 256.

## Test plan
- LANES=4, WIDTH=8, ROUNDS=0, SHL=4, SHR_A=5, SHR_B=3; in_data 0,0,0,0 -> out 0x03,0x04,0x06,0x09; out_valid exactly 8 cycles after accept.
- Same config, chain=1 after previous result -> out 0x0F,0x14,0x1C,0x28.
- Same config, in_data all 0xFF -> wrap: out 0x01,0x01,0x02,0x04.
- Defaults, in_data lanes 0..7, out_ready held 0 for 20 cycles -> out_data matches golden C model, stable while held, out_valid at accept+256, in_ready 0 throughout; in_valid pulses during busy ignored.
- Defaults, rst_n low 1 cycle at accept+100 -> out_valid never rises, out_data 0, in_ready 1 the cycle after reset release; new batch then matches model.
- 50 random batches (random chain, random out_ready delay), LANES=16, ROUNDS=3 -> every result matches model, latency 176.
